// File: rtl/rep_detect_if.sv
// rep_detect_if: configuration, upstream group and downstream beat signals
// for rep_detect.
//   configure, num_groups      : load the group count and start
//   data_in, valid_in          : one group of GROUP_SIZE values per transfer
//   avail_out                  : rep_detect can accept a group this cycle
//   data_out, valid_out        : one {matrix, value} beat per unique value
//   avail_in                   : downstream can take a beat this cycle
//   saved_count                : beats skipped for repeats (REP_DETECT_STATS_EN only)
// Modports: master = the environment around the block, slave = rep_detect.
interface rep_detect_if #(
    parameter int GROUP_SIZE     = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int LOG_MAX_GROUPS = 16
);
    localparam int OUTPUT_WIDTH = DATA_WIDTH + GROUP_SIZE * GROUP_SIZE;

    logic                             configure;
    logic [LOG_MAX_GROUPS-1:0]        num_groups;
    logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in;
    logic                             valid_in;
    logic                             avail_out;
    logic [OUTPUT_WIDTH-1:0]          data_out;
    logic                             valid_out;
    logic                             avail_in;
`ifdef REP_DETECT_STATS_EN
    logic [31:0]                      saved_count;

    modport master (output configure, num_groups, data_in, valid_in, avail_in,
                    input  avail_out, data_out, valid_out, saved_count);
    modport slave  (input  configure, num_groups, data_in, valid_in, avail_in,
                    output avail_out, data_out, valid_out, saved_count);
`else
    modport master (output configure, num_groups, data_in, valid_in, avail_in,
                    input  avail_out, data_out, valid_out);
    modport slave  (input  configure, num_groups, data_in, valid_in, avail_in,
                    output avail_out, data_out, valid_out);
`endif
endinterface

// File: rtl/rep_detect.sv
// rep_detect: builds the GROUP_SIZE x GROUP_SIZE repetition matrix for each
// group and emits one {matrix, value} beat per unique value, so the grouping
// stage downstream never repeats work for duplicated values.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : rep_detect_if.slave (configure/num_groups, data_in/valid_in/
//          avail_out, data_out/valid_out/avail_in)
// Optional: define REP_DETECT_STATS_EN to add bus.saved_count, a saturating
// count of beats skipped because of repeated values.
//
// state | meaning
// IDLE  | waiting for configure
// LOAD  | avail_out high, waiting for a group
// CMP   | compare latched elements, register matrix and pending mask
// EMIT  | send one beat per pending (unique) element
module rep_detect #(
    parameter int GROUP_SIZE     = 4,
    parameter int LOG_GROUP_SIZE = 2,
    parameter int DATA_WIDTH     = 16,
    parameter int LOG_MAX_GROUPS = 16
) (
    input  logic         clk,
    input  logic         rst,
    rep_detect_if.slave  bus
);
    localparam int REP_INFO = GROUP_SIZE * GROUP_SIZE;

    typedef enum logic [1:0] {IDLE, LOAD, CMP, EMIT} state_t;

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     elem_q [GROUP_SIZE];
    logic [REP_INFO-1:0]       matrix_q, matrix_c;
    logic [GROUP_SIZE-1:0]     pending_q, pending_clr, diag_c;
    logic [LOG_MAX_GROUPS-1:0] count_q;
    logic [LOG_GROUP_SIZE-1:0] sel_c;
    logic                      accept, xfer, last_beat;

    // Row r is populated only for the first occurrence of its value; later
    // duplicates get an all-zero row and no diagonal bit.
    always_comb begin
        matrix_c = '0;
        diag_c   = '0;
        for (int r = 0; r < GROUP_SIZE; r++) begin
            diag_c[r] = 1'b1;
            for (int j = 0; j < GROUP_SIZE; j++) begin
                if (j < r && elem_q[j] == elem_q[r]) diag_c[r] = 1'b0;
            end
            for (int i = 0; i < GROUP_SIZE; i++) begin
                matrix_c[r*GROUP_SIZE+i] = diag_c[r] && (elem_q[i] == elem_q[r]);
            end
        end
    end

    // Lowest pending index is the next beat.
    always_comb begin
        sel_c = '0;
        for (int k = GROUP_SIZE - 1; k >= 0; k--) begin
            if (pending_q[k]) sel_c = LOG_GROUP_SIZE'(k);
        end
        pending_clr        = pending_q;
        pending_clr[sel_c] = 1'b0;
        last_beat          = (pending_clr == '0);
    end

    assign bus.data_out = {matrix_q, elem_q[sel_c]};

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.avail_out = 1'b0;
        bus.valid_out = 1'b0;
        accept        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.configure && bus.num_groups != '0) state_d = LOAD;
            end
            LOAD: begin
                bus.avail_out = 1'b1;
                accept        = bus.valid_in && !bus.configure;
                if (accept) state_d = CMP;
            end
            CMP: state_d = EMIT;
            EMIT: begin
                bus.valid_out = (pending_q != '0) && bus.avail_in && !bus.configure;
                if (bus.valid_out && last_beat)
                    state_d = (count_q == LOG_MAX_GROUPS'(1)) ? IDLE : LOAD;
            end
            default: state_d = IDLE;
        endcase
        // configure aborts whatever is in flight and restarts from the new count
        if (bus.configure) state_d = (bus.num_groups != '0) ? LOAD : IDLE;
    end

    assign xfer = bus.valid_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < GROUP_SIZE; i++) elem_q[i] <= '0;
            matrix_q  <= '0;
            pending_q <= '0;
            count_q   <= '0;
        end else if (bus.configure) begin
            count_q   <= bus.num_groups;
            pending_q <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < GROUP_SIZE; i++)
                    elem_q[i] <= bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (state_q == CMP) begin
                matrix_q  <= matrix_c;
                pending_q <= diag_c;
            end
            if (xfer) begin
                pending_q <= pending_clr;
                if (last_beat) count_q <= count_q - LOG_MAX_GROUPS'(1);
            end
        end
    end

`ifdef REP_DETECT_STATS_EN
    logic [31:0] saved_q, saved_inc;
    logic [32:0] saved_sum;

    always_comb begin
        saved_inc = '0;
        for (int r = 0; r < GROUP_SIZE; r++) begin
            if (!diag_c[r]) saved_inc = saved_inc + 32'd1;
        end
        saved_sum = {1'b0, saved_q} + {1'b0, saved_inc};
    end

    always_ff @(posedge clk) begin
        if (rst || bus.configure)  saved_q <= '0;
        else if (state_q == CMP)   saved_q <= saved_sum[32] ? '1 : saved_sum[31:0];
    end

    assign bus.saved_count = saved_q;
`endif
endmodule

// File: tb/tb_rep_detect.sv
module tb_rep_detect;
    localparam int GS  = 4;
    localparam int DW  = 16;
    localparam int LMG = 16;
    localparam int OW  = DW + GS * GS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rep_detect_if #(.GROUP_SIZE(GS), .DATA_WIDTH(DW), .LOG_MAX_GROUPS(LMG)) bus ();

    rep_detect #(.GROUP_SIZE(GS), .LOG_GROUP_SIZE(2), .DATA_WIDTH(DW),
                 .LOG_MAX_GROUPS(LMG)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]    exp_vals [$];
    logic [GS*GS-1:0] exp_mat;
    longint           exp_saved = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unique values in first-occurrence order; each unique value
    // owns the row of its first index, marking every position holding it.
    task automatic build_model(input logic [GS*DW-1:0] g);
        logic [DW-1:0] v;
        bit seen;
        exp_vals.delete();
        exp_mat = '0;
        for (int r = 0; r < GS; r++) begin
            v = g[r*DW +: DW];
            seen = 0;
            foreach (exp_vals[q]) if (exp_vals[q] == v) seen = 1;
            if (!seen) begin
                exp_vals.push_back(v);
                for (int i = 0; i < GS; i++)
                    if (g[i*DW +: DW] == v) exp_mat[r*GS+i] = 1'b1;
            end
        end
    endtask

    task automatic do_config(input int n);
        @(negedge clk);
        bus.configure  = 1'b1;
        bus.num_groups = LMG'(n);
        bus.valid_in   = 1'b0;
        @(negedge clk);
        bus.configure  = 1'b0;
        exp_saved      = 0;
    endtask

    task automatic send_group(input logic [GS*DW-1:0] g);
        build_model(g);
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.data_in  = g;
        #1 check("avail_out_load", 64'(bus.avail_out), 64'd1);
        @(negedge clk);
        bus.valid_in = 1'b0;
        #1 check("cmp_no_valid", 64'(bus.valid_out), 64'd0);
        check("cmp_no_avail", 64'(bus.avail_out), 64'd0);
    endtask

    // mode 0: always ready; 1: random stalls; 2: 3-cycle stall after first beat
    task automatic collect(input int mode);
        int got = 0;
        int cyc = 0;
        int stall_cnt = 0;
        logic [OW-1:0] held = '0;
        while (got < exp_vals.size() && cyc < 200) begin
            @(negedge clk);
            cyc++;
            case (mode)
                0:       bus.avail_in = 1'b1;
                1:       bus.avail_in = ($urandom_range(0, 3) != 0);
                default: bus.avail_in = !(got == 1 && stall_cnt < 3);
            endcase
            #1;
            if (mode == 0 && cyc == 1) check("first_beat_latency", 64'(bus.valid_out), 64'd1);
            if (!bus.avail_in) begin
                check("stall_valid", 64'(bus.valid_out), 64'd0);
                if (mode == 2) begin
                    if (stall_cnt == 0) held = bus.data_out;
                    else check("stall_hold", 64'(bus.data_out), 64'(held));
                    stall_cnt++;
                end
            end else if (bus.valid_out) begin
                check("beat", 64'(bus.data_out), 64'({exp_mat, exp_vals[got]}));
                got++;
            end else if (mode != 1) begin
                check("back_to_back", 64'(bus.valid_out), 64'd1);
            end
        end
        check("beat_count", 64'(got), 64'(exp_vals.size()));
        exp_saved += GS - exp_vals.size();
`ifdef REP_DETECT_STATS_EN
        check("saved_count", 64'(bus.saved_count), 64'(exp_saved));
`endif
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        #1 check(tag, 64'(bus.avail_out), 64'd0);
    endtask

    function automatic logic [GS*DW-1:0] grp(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    logic [DW-1:0]    pool [5] = '{16'h0000, 16'h0001, 16'h8000, 16'h8001, 16'hFFFF};
    logic [GS*DW-1:0] rg;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.configure  = 1'b0;
        bus.num_groups = '0;
        bus.data_in    = '0;
        bus.valid_in   = 1'b0;
        bus.avail_in   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("rst_avail_out", 64'(bus.avail_out), 64'd0);
        check("rst_valid_out", 64'(bus.valid_out), 64'd0);
        check("rst_data_out", 64'(bus.data_out), 64'd0);
`ifdef REP_DETECT_STATS_EN
        check("rst_saved", 64'(bus.saved_count), 64'd0);
`endif
        do_config(0);
        #1 check("cfg_zero_idle", 64'(bus.avail_out), 64'd0);

        // directed patterns
        do_config(3);
        send_group(grp(1, 2, 3, 4)); collect(0);
        send_group(grp(7, 7, 7, 7)); collect(0);
        send_group(grp(5, 9, 5, 9)); collect(0);
        check_idle("idle_after_last");

        // backpressure after first beat
        do_config(1);
        send_group(grp(1, 2, 3, 4)); collect(2);
        check_idle("idle_after_stall");

        // count of 2, third group offered and ignored
        do_config(2);
        send_group(grp(3, 3, 8, 3)); collect(0);
        send_group(grp(0, 16'hFFFF, 16'h7FFF, 0)); collect(0);
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.data_in  = grp(1, 2, 3, 4);
        for (int i = 0; i < 6; i++) begin
            #1 check("third_avail", 64'(bus.avail_out), 64'd0);
            check("third_valid", 64'(bus.valid_out), 64'd0);
            @(negedge clk);
        end
        bus.valid_in = 1'b0;

        // reset during the second beat
        do_config(1);
        send_group(grp(1, 2, 3, 4));
        @(negedge clk);
        #1 check("rst_first_beat", 64'(bus.data_out), 64'({exp_mat, exp_vals[0]}));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_saved = 0;
        for (int i = 0; i < 4; i++) begin
            #1 check("post_rst_valid", 64'(bus.valid_out), 64'd0);
            check("post_rst_avail", 64'(bus.avail_out), 64'd0);
            @(negedge clk);
        end

        // configure aborts an emitting group
        do_config(2);
        send_group(grp(1, 2, 3, 4));
        @(negedge clk);
        #1 check("abort_first_beat", 64'(bus.data_out), 64'({exp_mat, exp_vals[0]}));
        @(negedge clk);
        bus.avail_in   = 1'b0;
        bus.configure  = 1'b1;
        bus.num_groups = LMG'(1);
        @(negedge clk);
        bus.configure = 1'b0;
        bus.avail_in  = 1'b1;
        exp_saved     = 0;
        #1 check("abort_to_load", 64'(bus.avail_out), 64'd1);
        check("abort_no_beat", 64'(bus.valid_out), 64'd0);
        send_group(grp(5, 9, 5, 9)); collect(0);
        check_idle("idle_after_abort");

        // randomized groups with random backpressure
        do_config(20);
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < GS; i++) rg[i*DW +: DW] = pool[$urandom_range(0, 4)];
            send_group(rg);
            collect(1);
        end
        bus.avail_in = 1'b1;
        check_idle("idle_after_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
